// File: rtl/clock_pkg.sv
// Shared encodings for the clock chain: edit_field values and the time_set_ctrl FSM states.
// Also used by the display driver and counter wrappers.
package clock_pkg;

   localparam logic [1:0] FLD_RUN = 2'd0;
   localparam logic [1:0] FLD_MIN = 2'd1;
   localparam logic [1:0] FLD_HR  = 2'd2;

   // State codes equal the edit_field codes, so the state register drives edit_field directly.
   typedef enum logic [1:0] {
      ST_RUN     = FLD_RUN,
      ST_SET_MIN = FLD_MIN,
      ST_SET_HR  = FLD_HR
   } state_t;

endpackage

// File: rtl/btn_repeat.sv
// Edge detect plus hold-to-repeat timer for one debounced button.
// rpt_pulse is combinational; the caller registers it.
module btn_repeat #(
   parameter int CNT_W      = 24,
   parameter int RPT_DELAY  = 12_500_000,
   parameter int RPT_PERIOD = 2_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic hold,
   output logic rpt_pulse
);

   logic             btn_q;
   logic             active;
   logic             in_period;
   logic [CNT_W-1:0] cnt;
   logic             rise;
   logic             due;

   assign rise      = btn & ~btn_q;
   // cnt holds the number of cycles since the edge or since the last repeat pulse
   assign due       = active & btn & (cnt == (in_period ? CNT_W'(RPT_PERIOD) : CNT_W'(RPT_DELAY)));
   assign rpt_pulse = ~hold & (rise | due);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q     <= 1'b0;
         active    <= 1'b0;
         in_period <= 1'b0;
         cnt       <= '0;
      end else begin
         btn_q <= btn;
         if (hold || !btn) begin
            active    <= 1'b0;
            in_period <= 1'b0;
            cnt       <= '0;
         end else if (rise) begin
            active    <= 1'b1;
            in_period <= 1'b0;
            cnt       <= CNT_W'(1);
         end else if (due) begin
            in_period <= 1'b1;
            cnt       <= CNT_W'(1);
         end else if (active) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/edit controller for the HH:MM:SS counter chain: field FSM, up/down routing, blink.
// Optional macro TIME_SET_AUTO_EXIT_EN adds the idle timeout back to RUN.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int CNT_W      = 24,
   parameter int RPT_DELAY  = 12_500_000,
   parameter int RPT_PERIOD = 2_500_000,
   parameter int TIMEOUT_S  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       sec_inc_auto,
   output logic       sec_clr,
   output logic       min_inc_man,
   output logic       min_dec_man,
   output logic       hr_inc_man,
   output logic       hr_dec_man,
   output logic [1:0] edit_field,
   output logic       blink
);

   state_t state, state_nx;
   logic   mode_q, mode_edge, rpt_hold;
   logic   up_evt, dn_evt, to_hit;
   logic   sec_inc_nx, sec_clr_nx, min_inc_nx, min_dec_nx, hr_inc_nx, hr_dec_nx, blink_nx;

   assign mode_edge = btn_mode & ~mode_q;
   // Both directions held cancels everything; a mode edge swallows any same-cycle up/down.
   assign rpt_hold  = (btn_up & btn_down) | mode_edge;

   btn_repeat #(.CNT_W(CNT_W), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_up (
      .clk(clk), .rst(rst), .btn(btn_up), .hold(rpt_hold), .rpt_pulse(up_evt));

   btn_repeat #(.CNT_W(CNT_W), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_dn (
      .clk(clk), .rst(rst), .btn(btn_down), .hold(rpt_hold), .rpt_pulse(dn_evt));

`ifdef TIME_SET_AUTO_EXIT_EN
   localparam int TO_W = $clog2(TIMEOUT_S + 1);
   logic [TO_W-1:0] to_cnt;
   logic            activity;

   assign activity = mode_edge | up_evt | dn_evt;
   assign to_hit   = tick_1hz & ~activity & (to_cnt == TO_W'(TIMEOUT_S - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             to_cnt <= '0;
      else if (state == ST_RUN || activity) to_cnt <= '0;
      else if (tick_1hz)                   to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
   if (TIMEOUT_S < 1) begin : g_bad_timeout
   end
`endif

   always_comb begin
      state_nx   = state;
      sec_clr_nx = 1'b0;
      min_inc_nx = 1'b0;
      min_dec_nx = 1'b0;
      hr_inc_nx  = 1'b0;
      hr_dec_nx  = 1'b0;
      sec_inc_nx = (state == ST_RUN) & tick_1hz;
      case (state)
         ST_RUN: begin
            if (mode_edge) begin
               state_nx   = ST_SET_MIN;
               sec_clr_nx = 1'b1;
            end
         end
         ST_SET_MIN: begin
            if (mode_edge) state_nx = ST_SET_HR;
            else begin
               min_inc_nx = up_evt;
               min_dec_nx = dn_evt;
            end
         end
         ST_SET_HR: begin
            if (mode_edge) state_nx = ST_RUN;
            else begin
               hr_inc_nx = up_evt;
               hr_dec_nx = dn_evt;
            end
         end
         default: state_nx = ST_RUN;
      endcase
      if (to_hit && state != ST_RUN && !mode_edge) state_nx = ST_RUN;

      blink_nx = blink;
      if (state_nx == ST_RUN || state_nx != state) blink_nx = 1'b0;
      else if (tick_1hz)                           blink_nx = ~blink;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_RUN;
         mode_q       <= 1'b0;
         sec_inc_auto <= 1'b0;
         sec_clr      <= 1'b0;
         min_inc_man  <= 1'b0;
         min_dec_man  <= 1'b0;
         hr_inc_man   <= 1'b0;
         hr_dec_man   <= 1'b0;
         blink        <= 1'b0;
      end else begin
         state        <= state_nx;
         mode_q       <= btn_mode;
         sec_inc_auto <= sec_inc_nx;
         sec_clr      <= sec_clr_nx;
         min_inc_man  <= min_inc_nx;
         min_dec_man  <= min_dec_nx;
         hr_inc_man   <= hr_inc_nx;
         hr_dec_man   <= hr_dec_nx;
         blink        <= blink_nx;
      end
   end

   assign edit_field = state;

endmodule
